// File: rtl/icosoc_irq_ctrl.sv
// Interrupt controller: latches per-source irqs, masks, arbitrates, claim/complete via ctrl bus.
// Latency: irq_in -> pending +1 cycle -> cpu_irq +2 cycles; ctrl_done one cycle after accept.
// Backpressure: one access per two cycles; IRQ_CTRL_ROUND_ROBIN_EN selects round-robin arbitration.
module icosoc_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ctrl_wr,
    input  logic               ctrl_rd,
    input  logic [7:0]         ctrl_addr,
    input  logic [31:0]        ctrl_wdat,
    output logic [31:0]        ctrl_rdat,
    output logic               ctrl_done,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               cpu_irq,
    output logic               in_service
);

    localparam logic [7:0] ADDR_PENDING  = 8'h00;
    localparam logic [7:0] ADDR_MASK     = 8'h04;
    localparam logic [7:0] ADDR_CLAIM    = 8'h08;
    localparam logic [7:0] ADDR_COMPLETE = 8'h0C;
    localparam logic [7:0] ADDR_RR_PTR   = 8'h10;

    typedef enum logic {IDLE, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] pending, mask, active, rot, clr;
    logic [4:0]         claimed_id, win_id, off;
    logic               accept, claim_ok, complete_ok, any_active;
    logic [31:0]        rd_dat;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    logic [4:0]           rr_ptr;
    logic [2*NUM_SRC-1:0] dbl;
    logic [5:0]           sum;
`endif

    wire unused_wdat = ^ctrl_wdat;

    assign accept      = (ctrl_wr || ctrl_rd) && !ctrl_done;
    assign active      = pending & mask;
    assign any_active  = |active;
    assign claim_ok    = accept && ctrl_rd && (ctrl_addr == ADDR_CLAIM)
                         && (state == IDLE) && any_active;
    assign complete_ok = accept && ctrl_wr && (ctrl_addr == ADDR_COMPLETE)
                         && (state == SERVICE) && (ctrl_wdat[4:0] == claimed_id);
    assign in_service  = (state == SERVICE);

    // Rotate the request vector so the search starts at offset 0, then map back.
    always_comb begin
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
        dbl = {active, active} >> rr_ptr;
        rot = dbl[NUM_SRC-1:0];
`else
        rot = active;
`endif
        off = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) off = 5'(k);
        end
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
        sum = {1'b0, off} + {1'b0, rr_ptr};
        if (sum >= 6'(NUM_SRC)) sum = sum - 6'(NUM_SRC);
        win_id = sum[4:0];
`else
        win_id = off;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (claim_ok) state_nxt = SERVICE;
            SERVICE: if (complete_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr = '0;
        if (accept && ctrl_wr && ctrl_addr == ADDR_PENDING) clr = ctrl_wdat[NUM_SRC-1:0];
        if (claim_ok) clr = clr | (NUM_SRC'(1) << win_id);
    end

    always_comb begin
        rd_dat = '0;
        case (ctrl_addr)
            ADDR_PENDING: rd_dat = 32'(pending);
            ADDR_MASK:    rd_dat = 32'(mask);
            ADDR_CLAIM:   rd_dat = claim_ok ? 32'(win_id) : 32'hFFFF_FFFF;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            ADDR_RR_PTR:  rd_dat = 32'(rr_ptr);
`endif
            default:      rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            mask       <= '0;
            claimed_id <= '0;
            cpu_irq    <= 1'b0;
            ctrl_done  <= 1'b0;
            ctrl_rdat  <= '0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            rr_ptr     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            // New requests override same-cycle clears.
            pending <= (pending & ~clr) | irq_in;
            if (accept && ctrl_wr && ctrl_addr == ADDR_MASK) mask <= ctrl_wdat[NUM_SRC-1:0];
            if (claim_ok) claimed_id <= win_id;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            if (claim_ok) rr_ptr <= (win_id == 5'(NUM_SRC - 1)) ? 5'd0 : win_id + 5'd1;
`endif
            cpu_irq   <= (state == IDLE) && !claim_ok && any_active;
            ctrl_done <= accept;
            ctrl_rdat <= accept ? rd_dat : '0;
        end
    end

endmodule

// File: tb/tb_icosoc_irq_ctrl.sv
// Directed bench for icosoc_irq_ctrl: bus accesses with hand-computed expectations.
module tb_icosoc_irq_ctrl;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_wr = 1'b0;
    logic        ctrl_rd = 1'b0;
    logic [7:0]  ctrl_addr = '0;
    logic [31:0] ctrl_wdat = '0;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;
    logic [7:0]  irq_in = '0;
    logic        cpu_irq;
    logic        in_service;

    int n_tests = 0;
    int n_fail  = 0;

    icosoc_irq_ctrl #(.NUM_SRC(8)) dut (
        .clk(clk), .reset(reset), .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd),
        .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat), .ctrl_rdat(ctrl_rdat),
        .ctrl_done(ctrl_done), .irq_in(irq_in), .cpu_irq(cpu_irq), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic wr, input logic rd, input logic [7:0] addr,
                       input logic [31:0] wdat, output logic [31:0] rdat);
        step();
        ctrl_wr = wr; ctrl_rd = rd; ctrl_addr = addr; ctrl_wdat = wdat;
        step();
        check("done", 32'(ctrl_done), 32'd1);
        rdat = ctrl_rdat;
        ctrl_wr = 1'b0; ctrl_rd = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b0, 1'b1, addr, 32'd0, d);
        check(tag, d, exp);
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wdat);
        logic [31:0] d;
        bus(1'b1, 1'b0, addr, wdat, d);
    endtask

    task automatic pulse(input logic [7:0] v);
        step(); irq_in = v;
        step(); irq_in = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        repeat (3) step();
        reset = 1'b0;
        check("rst_cpu_irq", 32'(cpu_irq), 0);
        check("rst_in_service", 32'(in_service), 0);
        check("rst_done", 32'(ctrl_done), 0);
        check("rst_rdat", ctrl_rdat, 0);
        rd_chk("rst_pending", 8'h00, 32'h0);
        rd_chk("rst_mask", 8'h04, 32'h0);
        rd_chk("rst_claim", 8'h08, 32'hFFFF_FFFF);
        rd_chk("unmapped", 8'h14, 32'h0);
        rd_chk("rst_ptr", 8'h10, 32'h0);

        // Held request: accepted every other cycle.
        step();
        ctrl_rd = 1'b1; ctrl_addr = 8'h00;
        step(); check("hold_done1", 32'(ctrl_done), 1);
        step(); check("hold_done2", 32'(ctrl_done), 0);
        step(); check("hold_done3", 32'(ctrl_done), 1);
        step(); check("hold_done4", 32'(ctrl_done), 0);
        ctrl_rd = 1'b0;

        // rd+wr together returns old value, write lands; upper mask bits drop.
        bus(1'b1, 1'b1, 8'h04, 32'hFFFF_FF0F, d);
        check("rdwr_old", d, 32'h0);
        rd_chk("rdwr_new", 8'h04, 32'h0F);

        // Single source latency and claim/complete.
        wr_reg(8'h04, 32'h04);
        step(); irq_in = 8'h04;
        step(); irq_in = '0;
        check("lat_t1", 32'(cpu_irq), 0);
        step();
        check("lat_t2", 32'(cpu_irq), 1);
        rd_chk("pend_4", 8'h00, 32'h04);
        rd_chk("claim_2", 8'h08, 32'd2);
        check("claim_insvc", 32'(in_service), 1);
        check("claim_irq", 32'(cpu_irq), 0);
        rd_chk("pend_clr", 8'h00, 32'h0);
        wr_reg(8'h0C, 32'd2);
        check("cmpl_insvc", 32'(in_service), 0);

        // Two sources: fixed priority vs round-robin from pointer 3.
        wr_reg(8'h04, 32'hFF);
        pulse(8'h22);
        rd_chk("arb_first", 8'h08, RR ? 32'd5 : 32'd1);
        wr_reg(8'h0C, RR ? 32'd5 : 32'd1);
        rd_chk("arb_second", 8'h08, RR ? 32'd1 : 32'd5);
        wr_reg(8'h0C, RR ? 32'd1 : 32'd5);
        check("arb_done", 32'(in_service), 0);
        rd_chk("ptr", 8'h10, RR ? 32'd2 : 32'd0);

        // Mismatched complete and nested claim ignored.
        pulse(8'h08);
        rd_chk("claim_3", 8'h08, 32'd3);
        wr_reg(8'h0C, 32'd4);
        check("bad_cmpl", 32'(in_service), 1);
        rd_chk("nest_claim", 8'h08, 32'hFFFF_FFFF);
        check("nest_insvc", 32'(in_service), 1);
        wr_reg(8'h0C, 32'd3);
        check("good_cmpl", 32'(in_service), 0);

        // W1C vs held request, then masking.
        wr_reg(8'h04, 32'h0);
        step(); irq_in = 8'h01;
        wr_reg(8'h00, 32'h01);
        irq_in = '0;
        rd_chk("set_wins", 8'h00, 32'h01);
        wr_reg(8'h00, 32'h01);
        rd_chk("w1c", 8'h00, 32'h0);
        pulse(8'h01);
        step();
        check("masked_irq", 32'(cpu_irq), 0);
        rd_chk("masked_pend", 8'h00, 32'h01);
        wr_reg(8'h04, 32'h01);
        check("unmask_t0", 32'(cpu_irq), 0);
        step();
        check("unmask_t1", 32'(cpu_irq), 1);

        // Complete in the same cycle a new irq arrives.
        rd_chk("claim_0", 8'h08, 32'd0);
        step();
        ctrl_wr = 1'b1; ctrl_addr = 8'h0C; ctrl_wdat = 32'd0; irq_in = 8'h01;
        step();
        ctrl_wr = 1'b0; irq_in = '0;
        check("cmpl_irq_idle", 32'(in_service), 0);
        check("cmpl_irq_t1", 32'(cpu_irq), 0);
        step();
        check("cmpl_irq_t2", 32'(cpu_irq), 1);

        // Reset during service.
        rd_chk("claim_0b", 8'h08, 32'd0);
        pulse(8'h02);
        check("pre_rst_insvc", 32'(in_service), 1);
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        check("mid_rst_insvc", 32'(in_service), 0);
        check("mid_rst_irq", 32'(cpu_irq), 0);
        rd_chk("mid_rst_pend", 8'h00, 32'h0);
        rd_chk("mid_rst_mask", 8'h04, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
